uart_alu_sequencer: RTL and testbench
=====================================

# uart_alu_sequencer

Packet-level controller between the UART receive stream and the UART transmit stream of the UART ALU. It parses the 4-byte command header (opcode, reserved, length LSB, length MSB), then does one of two things. For an ADD packet it assembles little-endian 32-bit operands from the payload into an accumulator and returns the 4-byte sum. For an ECHO packet it forwards the payload bytes to the transmit side. It owns all byte-level handshaking, so the UART cores only see plain valid/ready byte streams.

## Interface
- `WORD_WIDTH`, 32: operand/accumulator width; result is WORD_WIDTH/8 bytes.
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `s_axis_tdata_i` in 8: received byte from UART RX.
- `s_axis_tvalid_i` in 1: received byte valid.
- `s_axis_tready_o` out 1: sequencer accepts byte.
- `m_axis_tdata_o` out 8: byte to UART TX.
- `m_axis_tvalid_o` out 1: output byte valid.
- `m_axis_tready_i` in 1: UART TX accepts byte.
- `busy_o` out 1: high in any state other than OPCODE.
- `err_o` out 1: one-cycle pulse when an unknown opcode header completes.

## Operation
- States: OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, RESULT.
- OPCODE → RSVD → LEN_LO → LEN_HI each advance on one accepted byte.
  - OPCODE latches the opcode.
  - RSVD ignores its byte.
  - LEN_LO and LEN_HI latch the 16-bit length.
- Length counts header plus payload. Payload count = length − 4; length < 4 is treated as 4.
- Leaving LEN_HI:
  - payload count 0 and opcode ADD → RESULT;
  - payload count 0 and any other opcode → OPCODE;
  - otherwise → PAYLOAD with remaining-byte counter = payload count.
- ADD (8'h01):
  - Each payload byte shifts into a 32-bit word register at byte lane (index mod 4), little-endian.
  - On every 4th byte, and on the final byte, the word (unfilled lanes zero) is added into the accumulator, modulo 2^32.
  - After the final byte → RESULT.
- ECHO (8'hEC):
  - Each payload byte is loaded into the output holding register and presented on m_axis.
  - `s_axis_tready_o = !m_axis_tvalid_o || m_axis_tready_i`, a combinational path.
  - After the final byte is accepted → OPCODE. The last echoed byte may still be draining.
- Unknown opcode:
  - `err_o` pulses in the cycle LEN_HI is accepted.
  - Payload bytes are accepted and discarded.
  - No response is sent; the block then returns to OPCODE.
- RESULT: sends accumulator bytes 0..3, LSB first, one per m_axis handshake. After the byte-3 handshake → OPCODE, and the accumulator and word register clear.
- The reserved byte value has no effect.

## Timing
- Reset (async assert, sync deassert handled upstream) sets:
  - state OPCODE;
  - `s_axis_tready_o` = 0 while `rst_ni` is low, 1 in the first cycle after release;
  - `m_axis_tvalid_o` = 0, `m_axis_tdata_o` = 0;
  - `busy_o` = 0, `err_o` = 0;
  - accumulator and counters = 0.
- `s_axis_tready_o` is 1 in the header states and in ADD/unknown PAYLOAD, follows the ECHO rule above, and is 0 in RESULT.
- A byte is consumed only on the cycle where valid && ready; the input stream is never stalled otherwise.
- Result latency: final ADD payload byte accepted at cycle N → accumulator updated at N+1 edge → `m_axis_tvalid_o` = 1 with byte 0 at cycle N+1.
- Output bytes hold stable while `m_axis_tvalid_o` && !`m_axis_tready_i`. Valid is never withdrawn before the handshake.
- Back-to-back packets: `s_axis_tready_o` returns to 1 the cycle after the last result handshake.
- A new header may arrive while the last echo byte is draining. Its opcode byte is accepted only when ECHO output is free; header states are gated the same way while `m_axis_tvalid_o` is high.
- Remaining-byte counter is 16-bit and decrements per accepted payload byte. PAYLOAD exits when the counter reaches 1 on an accept, so there is no wrap.
- Reset asserted mid-packet aborts the packet immediately:
  - no partial result is sent;
  - the output register clears;
  - the next post-reset byte is parsed as an opcode.

## Structure
- Package `uart_alu_pkg` holds:
  - the state enum;
  - opcode constants OP_ADD = 8'h01 and OP_ECHO = 8'hEC;
  - HEADER_BYTES = 4.
- A single optional sub-module, `word_assembler`, packs bytes into a 32-bit word with lane index and a flush-on-last output. Everything else lives in one FSM module.

## Test plan
- ADD, len 12, operands 5 and 7 → output bytes 0C 00 00 00; `busy_o` falls after byte 3.
- ADD overflow, operands FFFFFFFF and 00000002 → 01 00 00 00.
- ADD, len 7 (3 payload bytes: 01 02 03) → partial word zero-extended → 01 02 03 00. ADD len 4 → 00 00 00 00.
- ECHO, len 8, payload DE AD BE EF, with `m_axis_tready_i` low for 10 cycles mid-stream → DE AD BE EF in order; no byte lost or duplicated; data stable while stalled.
- Opcode 55, len 6, payload AA BB → `err_o` single pulse, no output. A following ADD of 3 and 4 → 07 00 00 00.
- Reset asserted after 2 ADD payload bytes → all outputs at reset values. A fresh ADD of 1 and 1 → 02 00 00 00.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet sequencer.
// Header layout: opcode, reserved, length LSB, length MSB.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_RESULT
    } state_e;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam int         HEADER_BYTES = 4;

    // Length covers header plus payload; anything shorter than a header means no payload.
    function automatic logic [15:0] payload_count(input logic [15:0] len);
        return (len < 16'(HEADER_BYTES)) ? 16'd0 : len - 16'(HEADER_BYTES);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into WORD_WIDTH words; flushes on a full word
// or on the last byte, with unfilled upper lanes left at zero.
module word_assembler #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_byte_vld,
    input  logic [7:0]            i_byte,
    input  logic                  i_last,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_flush
);
    localparam int NB = WORD_WIDTH / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    logic [WORD_WIDTH-1:0] r_word;
    logic [LW-1:0]         r_lane;
    logic [WORD_WIDTH-1:0] w_word;

    // o_word already includes the byte being accepted this cycle.
    always_comb begin
        w_word = r_word;
        w_word[{r_lane, 3'b000} +: 8] = i_byte;
    end

    assign o_word  = w_word;
    assign o_flush = i_byte_vld && ((r_lane == LW'(NB - 1)) || i_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_byte_vld) begin
            if (o_flush) begin
                r_word <= '0;
                r_lane <= '0;
            end else begin
                r_word <= w_word;
                r_lane <= r_lane + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Packet FSM between UART RX and TX byte streams: header parse, ADD accumulate
// with little-endian result return, ECHO forwarding, silent discard of unknown opcodes.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_axis_tdata_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic       busy_o,
    output logic       err_o
);
    localparam int NB = WORD_WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    state_e                r_state, w_next;
    logic [7:0]            r_opcode;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_remaining;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [IW-1:0]         r_res_idx;
    logic [7:0]            r_tdata;
    logic                  r_out_vld;

    logic                  w_s_acc;
    logic                  w_m_hs;
    logic                  w_pay_acc;
    logic                  w_is_add;
    logic                  w_is_echo;
    logic                  w_last;
    logic                  w_out_free;
    logic                  w_res_done;
    logic [15:0]           w_payload;
    logic [WORD_WIDTH-1:0] w_wa_word;
    logic                  w_wa_flush;

    assign w_s_acc    = s_axis_tvalid_i && s_axis_tready_o;
    assign w_m_hs     = m_axis_tvalid_o && m_axis_tready_i;
    assign w_pay_acc  = (r_state == ST_PAYLOAD) && w_s_acc;
    assign w_is_add   = (r_opcode == OP_ADD);
    assign w_is_echo  = (r_opcode == OP_ECHO);
    assign w_last     = (r_remaining == 16'd1);
    assign w_out_free = !r_out_vld || m_axis_tready_i;
    assign w_payload  = payload_count({s_axis_tdata_i, r_len_lo});
    assign w_res_done = (r_state == ST_RESULT) && w_m_hs && (r_res_idx == IW'(NB - 1));

    word_assembler #(.WORD_WIDTH(WORD_WIDTH)) u_word (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_clr      (w_res_done),
        .i_byte_vld (w_pay_acc && w_is_add),
        .i_byte     (s_axis_tdata_i),
        .i_last     (w_last),
        .o_word     (w_wa_word),
        .o_flush    (w_wa_flush)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_OPCODE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OPCODE: if (w_s_acc) w_next = ST_RSVD;
            ST_RSVD:   if (w_s_acc) w_next = ST_LEN_LO;
            ST_LEN_LO: if (w_s_acc) w_next = ST_LEN_HI;
            ST_LEN_HI: if (w_s_acc) begin
                if (w_payload != 16'd0) w_next = ST_PAYLOAD;
                else                    w_next = w_is_add ? ST_RESULT : ST_OPCODE;
            end
            ST_PAYLOAD: if (w_s_acc && w_last) w_next = w_is_add ? ST_RESULT : ST_OPCODE;
            ST_RESULT:  if (w_res_done) w_next = ST_OPCODE;
            default:    w_next = ST_OPCODE;
        endcase
    end

    // Header bytes wait for a draining echo byte so the holding register is free.
    always_comb begin
        s_axis_tready_o = w_out_free;
        m_axis_tvalid_o = r_out_vld;
        m_axis_tdata_o  = r_tdata;
        case (r_state)
            ST_PAYLOAD: s_axis_tready_o = w_is_echo ? w_out_free : 1'b1;
            ST_RESULT: begin
                s_axis_tready_o = 1'b0;
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = r_acc[{r_res_idx, 3'b000} +: 8];
            end
            default: ;
        endcase
        s_axis_tready_o = s_axis_tready_o && rst_ni;
        busy_o = (r_state != ST_OPCODE);
        err_o  = (r_state == ST_LEN_HI) && w_s_acc && !w_is_add && !w_is_echo;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opcode    <= '0;
            r_len_lo    <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
            r_res_idx   <= '0;
            r_tdata     <= '0;
            r_out_vld   <= 1'b0;
        end else begin
            if ((r_state == ST_OPCODE) && w_s_acc) r_opcode <= s_axis_tdata_i;
            if ((r_state == ST_LEN_LO) && w_s_acc) r_len_lo <= s_axis_tdata_i;

            if ((r_state == ST_LEN_HI) && w_s_acc) r_remaining <= w_payload;
            else if (w_pay_acc)                    r_remaining <= r_remaining - 16'd1;

            if (w_res_done)      r_acc <= '0;
            else if (w_wa_flush) r_acc <= r_acc + w_wa_word;

            if (w_res_done)                            r_res_idx <= '0;
            else if ((r_state == ST_RESULT) && w_m_hs) r_res_idx <= r_res_idx + 1'b1;

            if (w_pay_acc && w_is_echo) begin
                r_tdata   <= s_axis_tdata_i;
                r_out_vld <= 1'b1;
            end else if (m_axis_tready_i) begin
                r_out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed plus randomized packets against a byte-level reference model of the
// ADD / ECHO / unknown-opcode packet protocol.
module tb_uart_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    uart_alu_sequencer #(.WORD_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .s_axis_tdata_i  (s_tdata),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .m_axis_tdata_o  (m_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .busy_o          (busy),
        .err_o           (err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got[$];
    logic [7:0] expq[$];
    logic [7:0] pl[$];
    int         stall = 0;
    bit         throttle = 0;
    int         err_cnt = 0;
    bit         prev_stalled = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sink side: drive m_tready each cycle, record handshakes, watch hold behaviour.
    initial begin
        forever begin
            @(negedge clk);
            if (stall > 0) begin
                m_tready = 1'b0;
                stall--;
            end else begin
                m_tready = throttle ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #3;
            if (err) err_cnt++;
            if (prev_stalled && rst_n) begin
                chk("hold_valid", 32'(m_tvalid), 32'd1);
                chk("hold_data", 32'(m_tdata), 32'(prev_data));
            end
            if (m_tvalid && m_tready && rst_n) got.push_back(m_tdata);
            prev_stalled = m_tvalid && !m_tready && rst_n;
            prev_data    = m_tdata;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        s_tdata  = b;
        s_tvalid = 1'b1;
        #2;
        while (!s_tready && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!s_tready) chk("accept_timeout", 32'(s_tready), 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    // Reference: ADD sums each byte at weight 256^(index mod 4); ECHO copies payload.
    task automatic build_exp(input logic [7:0] op);
        logic [31:0] sum;
        expq.delete();
        if (op == 8'h01) begin
            sum = 32'd0;
            foreach (pl[i]) sum = sum + (32'(pl[i]) << (8 * (i % 4)));
            for (int k = 0; k < 4; k++) expq.push_back(8'(sum >> (8 * k)));
        end else if (op == 8'hEC) begin
            foreach (pl[i]) expq.push_back(pl[i]);
        end
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [15:0] len,
                               input bit gap, input int stall_at);
        build_exp(op);
        send_byte(op);
        send_byte(8'($urandom));
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        foreach (pl[i]) begin
            if (i == stall_at) stall = 10;
            if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(pl[i]);
        end
    endtask

    task automatic check_resp(input string tag, input bit exp_err);
        int n = 0;
        while (got.size() < expq.size() && n < 500) begin
            @(negedge clk);
            #4;
            n++;
        end
        repeat (6) @(negedge clk);
        #4;
        chk({tag, "_count"}, 32'(got.size()), 32'(expq.size()));
        foreach (expq[i])
            chk({tag, "_byte"}, (i < got.size()) ? 32'(got[i]) : 32'hxxxxxxxx, 32'(expq[i]));
        chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
        got.delete();
        err_cnt = 0;
    endtask

    initial begin
        logic [7:0]  op;
        logic [15:0] len;
        int          cnt;

        #2;
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata",  32'(m_tdata),  32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_err",    32'(err),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("rel_tready", 32'(s_tready), 32'd1);

        pl = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        send_packet(8'h01, 16'd12, 1'b0, -1);
        chk("add_busy_mid", 32'(busy), 32'd1);
        check_resp("add_5_7", 1'b0);
        chk("add_busy_idle", 32'(busy), 32'd0);
        chk("add_ready_idle", 32'(s_tready), 32'd1);

        pl = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        send_packet(8'h01, 16'd12, 1'b0, -1);
        check_resp("add_ovf", 1'b0);

        pl = '{8'h01, 8'h02, 8'h03};
        send_packet(8'h01, 16'd7, 1'b0, -1);
        check_resp("add_partial", 1'b0);

        pl.delete();
        send_packet(8'h01, 16'd4, 1'b0, -1);
        check_resp("add_empty", 1'b0);

        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_packet(8'hEC, 16'd8, 1'b0, 2);
        check_resp("echo_stall", 1'b0);

        pl = '{8'hAA, 8'hBB};
        send_packet(8'h55, 16'd6, 1'b0, -1);
        check_resp("unknown_op", 1'b1);
        pl = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_packet(8'h01, 16'd12, 1'b0, -1);
        check_resp("add_after_err", 1'b0);

        // Abort an ADD after two payload bytes.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'd12);
        send_byte(8'd0);
        send_byte(8'h09);
        send_byte(8'h09);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_tready", 32'(s_tready), 32'd0);
        chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_tdata",  32'(m_tdata),  32'd0);
        chk("mid_rst_busy",   32'(busy),     32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("mid_rel_tready", 32'(s_tready), 32'd1);
        got.delete();
        err_cnt = 0;
        pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        send_packet(8'h01, 16'd12, 1'b0, -1);
        check_resp("add_post_rst", 1'b0);

        throttle = 1;
        for (int p = 0; p < 25; p++) begin
            case ($urandom_range(0, 2))
                0:       op = 8'h01;
                1:       op = 8'hEC;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h01 || op == 8'hEC) op = 8'h77;
                end
            endcase
            len = 16'($urandom_range(0, 24));
            cnt = (len < 4) ? 0 : int'(len) - 4;
            pl.delete();
            for (int k = 0; k < cnt; k++) pl.push_back(8'($urandom));
            send_packet(op, len, 1'b1, -1);
            check_resp("rand_pkt", (op != 8'h01 && op != 8'hEC));
        end
        throttle = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
